data_memory: RTL and testbench



---
 rtl/mem_pkg.sv | 62 ++++++
 rtl/mem_byte_bank.sv | 28 ++
 rtl/data_memory.sv | 161 ++++++++++++++++
 tb/tb_data_memory.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the byte-addressable data memory.
package mem_pkg;

    // Access size encodings (load and store share them)
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BAD  = 2'b10;
    localparam logic [1:0] SIZE_BYTE = 2'b11;

    // Dump sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FETCH   = 2'b01,
        PRESENT = 2'b10
    } dump_state_t;

    // Per-lane write enables plus the store data already replicated onto lanes
    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] data;
    } lane_steer_t;

    // True when an access of this size may start at this lane
    function automatic logic access_ok(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        case (size)
            SIZE_WORD: ok = (lane == 2'b00);
            SIZE_HALF: ok = ~lane[0];
            SIZE_BYTE: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Replicate the low bytes of store data across lanes and pick the lanes to write
    function automatic lane_steer_t steer_store(input logic [1:0] size, input logic [1:0] lane,
                                                input logic [31:0] data);
        lane_steer_t s;
        s.we   = 4'b0000;
        s.data = 32'h0;
        case (size)
            SIZE_WORD: begin
                s.we   = 4'b1111;
                s.data = data;
            end
            SIZE_HALF: begin
                s.we   = lane[1] ? 4'b1100 : 4'b0011;
                s.data = {2{data[15:0]}};
            end
            SIZE_BYTE: begin
                s.we   = 4'b0001 << lane;
                s.data = {4{data[7:0]}};
            end
            default: begin
                s.we   = 4'b0000;
                s.data = 32'h0;
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_byte_bank.sv
// One byte lane of storage: single write port, two registered read ports.
// Reads sample the array before a same-edge write lands (read-before-write).
module mem_byte_bank #(
    parameter int N_WORDS = 64,
    parameter int AW      = $clog2(N_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          ra_en,
    input  logic [AW-1:0] ra_addr,
    output logic [7:0]    ra_data,
    input  logic          rb_en,
    input  logic [AW-1:0] rb_addr,
    output logic [7:0]    rb_data
);

    logic [7:0] mem [N_WORDS];

    // Storage is intentionally not reset; read registers only update when enabled
    always_ff @(posedge clk) begin
        if (we)    mem[waddr] <= wdata;
        if (ra_en) ra_data    <= mem[ra_addr];
        if (rb_en) rb_data    <= mem[rb_addr];
    end

endmodule

// File: rtl/data_memory.sv
// MEM-stage data memory: four byte banks, aligned load/store with extension,
// misalignment reporting and a full-memory dump sequencer on a second read port.
module data_memory
    import mem_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int N_WORDS = 64,
    parameter int NB_ADDR = $clog2(N_WORDS*4)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_r_en,
    input  logic [NB_ADDR-1:0] i_r_addr,
    input  logic [1:0]         i_r_size,
    input  logic               i_r_unsigned,
    input  logic               i_w_en,
    input  logic [NB_ADDR-1:0] i_w_addr,
    input  logic [1:0]         i_w_size,
    input  logic [NB_DATA-1:0] i_w_data,
    output logic [NB_DATA-1:0] o_r_data,
    output logic               o_r_valid,
    output logic               o_misalign,
    input  logic               i_dbg_start,
    input  logic               i_dbg_ready,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic [NB_ADDR-1:0] o_dbg_addr,
    output logic               o_dbg_valid,
    output logic               o_dbg_last,
    output logic               o_dbg_busy
);

    localparam int NB_WADDR = NB_ADDR - 2;

    logic [NB_WADDR-1:0] r_word, w_word;
    logic [1:0]          r_lane, w_lane;
    logic                r_ok, w_ok, r_bad, w_bad;
    lane_steer_t         w_steer;
    logic [3:0]          bank_we;
    logic [NB_DATA-1:0]  rd_word, dump_word;

    logic                r_valid_q, r_bad_q, r_uns_q, mis_q;
    logic [1:0]          r_size_q, r_lane_q;
    logic [15:0]         half_sel;
    logic [7:0]          byte_sel;
    logic [NB_DATA-1:0]  load_ext;

    dump_state_t         state_q, state_d;
    logic [NB_WADDR-1:0] cnt_q;
    logic                dump_fetch, dump_last;

    assign r_word  = i_r_addr[NB_ADDR-1:2];
    assign r_lane  = i_r_addr[1:0];
    assign w_word  = i_w_addr[NB_ADDR-1:2];
    assign w_lane  = i_w_addr[1:0];
    assign r_ok    = access_ok(i_r_size, r_lane);
    assign w_ok    = access_ok(i_w_size, w_lane);
    assign r_bad   = i_r_en & ~r_ok;
    assign w_bad   = i_w_en & ~w_ok;
    assign w_steer = steer_store(i_w_size, w_lane, i_w_data);
    // A bad store must leave every bank untouched
    assign bank_we = (i_w_en & w_ok) ? w_steer.we : 4'b0000;

    generate
        for (genvar b = 0; b < 4; b++) begin : g_bank
            mem_byte_bank #(.N_WORDS(N_WORDS), .AW(NB_WADDR)) u_bank (
                .clk     (i_clk),
                .we      (bank_we[b]),
                .waddr   (w_word),
                .wdata   (w_steer.data[8*b +: 8]),
                .ra_en   (i_r_en & r_ok),
                .ra_addr (r_word),
                .ra_data (rd_word[8*b +: 8]),
                .rb_en   (dump_fetch),
                .rb_addr (cnt_q),
                .rb_data (dump_word[8*b +: 8])
            );
        end
    endgenerate

    // Load side-band registered alongside the bank read; one misalign pulse covers both ports
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid_q <= 1'b0;
            r_bad_q   <= 1'b0;
            r_size_q  <= 2'b00;
            r_lane_q  <= 2'b00;
            r_uns_q   <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            r_valid_q <= i_r_en;
            r_bad_q   <= r_bad;
            r_size_q  <= i_r_size;
            r_lane_q  <= r_lane;
            r_uns_q   <= i_r_unsigned;
            mis_q     <= r_bad | w_bad;
        end
    end

    // Lane select and sign/zero extension; zero when idle or the load was rejected
    always_comb begin
        half_sel = r_lane_q[1] ? rd_word[31:16] : rd_word[15:0];
        byte_sel = rd_word[{r_lane_q, 3'b000} +: 8];
        load_ext = '0;
        if (r_valid_q && !r_bad_q) begin
            case (r_size_q)
                SIZE_WORD: load_ext = rd_word;
                SIZE_HALF: load_ext = {{16{half_sel[15] & ~r_uns_q}}, half_sel};
                SIZE_BYTE: load_ext = {{24{byte_sel[7] & ~r_uns_q}}, byte_sel};
                default:   load_ext = '0;
            endcase
        end
    end

    assign o_r_data   = load_ext;
    assign o_r_valid  = r_valid_q;
    assign o_misalign = mis_q;

    assign dump_last = (cnt_q == NB_WADDR'(N_WORDS - 1));

    // Dump state and word counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && i_dbg_start)
                cnt_q <= '0;
            else if (state_q == PRESENT && i_dbg_ready && !dump_last)
                cnt_q <= cnt_q + NB_WADDR'(1);
        end
    end

    // Dump next-state: start only from IDLE, advance on each accepted word
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_dbg_start) state_d = FETCH;
            FETCH:   state_d = PRESENT;
            PRESENT: if (i_dbg_ready) state_d = dump_last ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Dump outputs; the fetched word sits in the bank read register until the next FETCH
    always_comb begin
        dump_fetch  = 1'b0;
        o_dbg_valid = 1'b0;
        o_dbg_busy  = 1'b1;
        case (state_q)
            IDLE:    o_dbg_busy  = 1'b0;
            FETCH:   dump_fetch  = 1'b1;
            PRESENT: o_dbg_valid = 1'b1;
            default: o_dbg_busy  = 1'b0;
        endcase
        o_dbg_last = o_dbg_valid & dump_last;
        o_dbg_data = o_dbg_valid ? dump_word : '0;
        o_dbg_addr = {cnt_q, 2'b00};
    end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: byte-array reference model checked every cycle,
// directed literal cases, randomized traffic, dump and mid-dump reset.
module tb_data_memory;

    localparam int N_WORDS = 64;
    localparam int NB_ADDR = 8;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_r_en = 1'b0;
    logic [NB_ADDR-1:0] i_r_addr = '0;
    logic [1:0]         i_r_size = 2'b00;
    logic               i_r_unsigned = 1'b0;
    logic               i_w_en = 1'b0;
    logic [NB_ADDR-1:0] i_w_addr = '0;
    logic [1:0]         i_w_size = 2'b00;
    logic [31:0]        i_w_data = '0;
    logic [31:0]        o_r_data;
    logic               o_r_valid;
    logic               o_misalign;
    logic               i_dbg_start = 1'b0;
    logic               i_dbg_ready = 1'b0;
    logic [31:0]        o_dbg_data;
    logic [NB_ADDR-1:0] o_dbg_addr;
    logic               o_dbg_valid;
    logic               o_dbg_last;
    logic               o_dbg_busy;

    data_memory #(.NB_DATA(32), .N_WORDS(N_WORDS), .NB_ADDR(NB_ADDR)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_r_en(i_r_en), .i_r_addr(i_r_addr), .i_r_size(i_r_size), .i_r_unsigned(i_r_unsigned),
        .i_w_en(i_w_en), .i_w_addr(i_w_addr), .i_w_size(i_w_size), .i_w_data(i_w_data),
        .o_r_data(o_r_data), .o_r_valid(o_r_valid), .o_misalign(o_misalign),
        .i_dbg_start(i_dbg_start), .i_dbg_ready(i_dbg_ready),
        .o_dbg_data(o_dbg_data), .o_dbg_addr(o_dbg_addr), .o_dbg_valid(o_dbg_valid),
        .o_dbg_last(o_dbg_last), .o_dbg_busy(o_dbg_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mdl [N_WORDS*4];
    logic        exp_valid = 1'b0;
    logic        exp_mis = 1'b0;
    logic [31:0] exp_data = '0;

    function automatic bit legal(input logic [1:0] size, input int addr);
        if (size == 2'b00) return (addr % 4) == 0;
        if (size == 2'b01) return (addr % 2) == 0;
        if (size == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic [31:0] model_word(input int w);
        return {mdl[4*w+3], mdl[4*w+2], mdl[4*w+1], mdl[4*w]};
    endfunction

    // Loads see the array as it was before this edge's store
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exp_valid = 1'b0;
            exp_mis   = 1'b0;
            exp_data  = '0;
        end else begin
            int ra, wa, n;
            bit rok, wok;
            logic [31:0] v;
            ra  = int'(i_r_addr);
            wa  = int'(i_w_addr);
            rok = legal(i_r_size, ra);
            wok = legal(i_w_size, wa);
            exp_valid = i_r_en;
            exp_mis   = (i_r_en && !rok) || (i_w_en && !wok);
            v = 32'h0;
            if (i_r_en && rok) begin
                n = nbytes(i_r_size);
                for (int k = 0; k < n; k++) v = v | (32'(mdl[ra+k]) << (8*k));
                if (n < 4 && !i_r_unsigned && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            end
            exp_data = v;
            if (i_w_en && wok) begin
                n = nbytes(i_w_size);
                for (int k = 0; k < n; k++) mdl[wa+k] = i_w_data[8*k +: 8];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int          dk = 0;
    int          hs_total = 0;
    int          last_total = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_data = '0;

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            chk("r_valid", 32'(o_r_valid), 32'(exp_valid));
            chk("misalign", 32'(o_misalign), 32'(exp_mis));
            if (exp_valid) chk("r_data", o_r_data, exp_data);
            if (!o_dbg_busy) begin
                dk = 0;
                chk("dbg_valid_idle", 32'(o_dbg_valid), 32'h0);
            end
            if (o_dbg_valid) begin
                chk("dbg_addr", 32'(o_dbg_addr), 32'(4*dk));
                chk("dbg_data", o_dbg_data, model_word(dk));
                chk("dbg_last", 32'(o_dbg_last), 32'(dk == N_WORDS-1));
                if (prev_valid && !prev_ready) chk("dbg_stable", o_dbg_data, prev_data);
                if (i_dbg_ready) begin
                    hs_total++;
                    if (o_dbg_last) last_total++;
                    dk++;
                end
            end else begin
                chk("dbg_last_novalid", 32'(o_dbg_last), 32'h0);
            end
            prev_valid = o_dbg_valid;
            prev_ready = i_dbg_ready;
            prev_data  = o_dbg_data;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic store(input int addr, input logic [1:0] size, input logic [31:0] data);
        i_w_en = 1'b1; i_w_addr = NB_ADDR'(addr); i_w_size = size; i_w_data = data;
        @(posedge i_clk); #1;
        i_w_en = 1'b0;
    endtask

    task automatic load_chk(input string name, input int addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] expd, input logic mis);
        i_r_en = 1'b1; i_r_addr = NB_ADDR'(addr); i_r_size = size; i_r_unsigned = uns;
        @(posedge i_clk); #1;
        i_r_en = 1'b0;
        @(negedge i_clk);
        chk(name, o_r_data, expd);
        chk({name, "_mis"}, 32'(o_misalign), 32'(mis));
    endtask

    task automatic store_mis_chk(input string name, input int addr, input logic [1:0] size,
                                 input logic [31:0] data);
        store(addr, size, data);
        @(negedge i_clk);
        chk(name, 32'(o_misalign), 32'h1);
    endtask

    task automatic fill_index();
        for (int i = 0; i < N_WORDS; i++) store(4*i, 2'b00, 32'(i));
    endtask

    initial begin
        int h0, l0, budget;
        bit done;

        // reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_outputs", {o_r_data[7:0], 8'(o_dbg_data | 32'(o_dbg_addr)),
                            3'b0, o_r_valid, o_misalign, o_dbg_valid, o_dbg_last, o_dbg_busy, 8'h0},
            32'h0);
        chk("rst_r_data", o_r_data, 32'h0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        fill_index();

        // word store, byte/half extraction
        store(32'h10, 2'b00, 32'hDEADBEEF);
        load_chk("lw_10", 32'h10, 2'b00, 1'b0, 32'hDEADBEEF, 1'b0);
        load_chk("lbu_13", 32'h13, 2'b11, 1'b1, 32'h000000DE, 1'b0);
        load_chk("lb_13", 32'h13, 2'b11, 1'b0, 32'hFFFFFFDE, 1'b0);
        load_chk("lb_10", 32'h10, 2'b11, 1'b0, 32'hFFFFFFEF, 1'b0);

        // half store into upper lanes leaves lower lanes alone
        store(32'h20, 2'b00, 32'h12345678);
        store(32'h22, 2'b01, 32'h00008001);
        load_chk("lh_22", 32'h22, 2'b01, 1'b0, 32'hFFFF8001, 1'b0);
        load_chk("lhu_22", 32'h22, 2'b01, 1'b1, 32'h00008001, 1'b0);
        load_chk("lw_20", 32'h20, 2'b00, 1'b0, 32'h80015678, 1'b0);
        load_chk("lw_20_uns_ignored", 32'h20, 2'b00, 1'b1, 32'h80015678, 1'b0);

        // misaligned and illegal accesses
        store(32'h04, 2'b00, 32'hCAFEF00D);
        load_chk("lw_06_mis", 32'h06, 2'b00, 1'b0, 32'h0, 1'b1);
        store_mis_chk("sh_05_mis", 32'h05, 2'b01, 32'h0000BEEF);
        store_mis_chk("s10_04_mis", 32'h04, 2'b10, 32'h55555555);
        load_chk("lw_04_unchanged", 32'h04, 2'b00, 1'b0, 32'hCAFEF00D, 1'b0);
        load_chk("l10_04_mis", 32'h04, 2'b10, 1'b0, 32'h0, 1'b1);

        // same-cycle store and load to one word: old data first
        store(32'h30, 2'b00, 32'hAAAAAAAA);
        i_w_en = 1'b1; i_w_addr = 8'h30; i_w_size = 2'b00; i_w_data = 32'h11111111;
        load_chk("rbw_old", 32'h30, 2'b00, 1'b0, 32'hAAAAAAAA, 1'b0);
        i_w_en = 1'b0;
        load_chk("rbw_new", 32'h30, 2'b00, 1'b0, 32'h11111111, 1'b0);

        // both ports misaligned: one pulse only
        i_w_en = 1'b1; i_w_addr = 8'h03; i_w_size = 2'b01; i_w_data = 32'h0;
        load_chk("both_mis", 32'h01, 2'b00, 1'b0, 32'h0, 1'b1);
        i_w_en = 1'b0;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("mis_single_pulse", 32'(o_misalign), 32'h0);
        load_chk("lw_00_after_mis", 32'h00, 2'b00, 1'b0, 32'h0, 1'b0);

        // randomized traffic
        @(posedge i_clk); #1;
        for (int i = 0; i < 400; i++) begin
            i_r_en       = ($urandom_range(0, 99) < 70);
            i_r_addr     = NB_ADDR'($urandom);
            i_r_size     = 2'($urandom);
            i_r_unsigned = 1'($urandom);
            i_w_en       = ($urandom_range(0, 99) < 50);
            i_w_addr     = NB_ADDR'($urandom);
            i_w_size     = 2'($urandom);
            i_w_data     = $urandom;
            @(posedge i_clk); #1;
        end
        i_r_en = 1'b0; i_w_en = 1'b0;

        // dump with random back-pressure, start re-pulsed while busy
        fill_index();
        h0 = hs_total; l0 = last_total;
        i_dbg_start = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 1500 && !done; c++) begin
            @(posedge i_clk); #1;
            i_dbg_start = (c == 10);
            i_dbg_ready = ($urandom_range(0, 99) < 55);
            @(negedge i_clk); #1;
            if (hs_total - h0 == N_WORDS) done = 1'b1;
            else chk("dump_busy", 32'(o_dbg_busy), 32'h1);
        end
        chk("dump_completed", 32'(done), 32'h1);
        @(posedge i_clk); #1;
        i_dbg_ready = 1'b0;
        @(negedge i_clk);
        chk("dump_idle_busy", 32'(o_dbg_busy), 32'h0);
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        chk("start_in_busy_ignored", 32'(o_dbg_busy), 32'h0);
        chk("dump_words", 32'(hs_total - h0), 32'(N_WORDS));
        chk("dump_last_count", 32'(last_total - l0), 32'h1);

        // reset in the middle of a dump
        @(posedge i_clk); #1;
        i_dbg_ready = 1'b1;
        i_dbg_start = 1'b1;
        @(posedge i_clk); #1;
        i_dbg_start = 1'b0;
        budget = 0;
        done = 1'b0;
        while (!done && budget < 300) begin
            @(negedge i_clk);
            budget++;
            if (o_dbg_valid && o_dbg_addr == 8'(4*20)) done = 1'b1;
        end
        chk("reached_word20", 32'(done), 32'h1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(o_dbg_busy), 32'h0);
        chk("abort_valid", 32'(o_dbg_valid), 32'h0);
        chk("abort_last", 32'(o_dbg_last), 32'h0);
        i_dbg_ready = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        load_chk("lw_after_rst_20", 4*20, 2'b00, 1'b0, 32'd20, 1'b0);
        load_chk("lw_after_rst_63", 4*63, 2'b00, 1'b0, 32'd63, 1'b0);
        chk("abort_no_last", 32'(last_total - l0), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
